fc_argmax_classifier: RTL and testbench
=======================================

Name: fc_argmax_classifier

Overview:
- Output stage placed directly downstream of the fully connected layer.
- Accepts one fully-connected neuron result per handshake beat, NUM_CLASSES beats per frame.
- Applies an optional ReLU to each result and tracks the running maximum.
- At frame end, presents the winning class index and its score on a valid/ready output.
- Data format is the layer's sign-magnitude fixed point: bit N-1 is the sign, bits N-2:0 are the magnitude, and the low Q bits are fractional.

Parameters:
- NUM_CLASSES, 10, neuron outputs per frame (must be >= 2)
- N, 32, data word width
- Q, 15, fractional bits (used only for score interpretation; the datapath is format-agnostic)
- RELU_EN, 1, 1 = clamp negative inputs to +0 before comparison and reporting
- CW, $clog2(NUM_CLASSES), class index width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  in_data holds a neuron result
- in_ready  out  1  block can accept a beat
- in_data  in  N  sign-magnitude neuron result
- in_last  in  1  marks the final beat of a frame
- out_valid  out  1  classification result available
- out_ready  in  1  consumer accepts the result
- out_class  out  CW  index of the maximum (0-based beat order)
- out_score  out  N  maximum value (post-ReLU if enabled, -0 normalised to +0)
- frame_err  out  1  one-cycle pulse on a framing error

Behaviour:
- Reset (rst=1 at a clk edge): state=ACCUM, beat count=0, in_ready=1, out_valid=0, out_class=0, out_score=0, frame_err=0, running max cleared. Reset takes precedence over every other event, including a mid-frame or pending-output state; any partial frame is discarded.
- Beat accepted when in_valid && in_ready.
- in_ready = (state==ACCUM); it is combinational from state only and never depends on in_valid.
- Value conditioning per beat:
  - If RELU_EN and sign=1, v = 0.
  - Any value with magnitude 0 becomes all-zeros.
- Comparison is signed sign-magnitude:
  - Positive beats negative.
  - Among two positives, the larger magnitude wins.
  - Among two negatives, the smaller magnitude wins.
  - +0 and -0 are equal.
- The first beat of a frame (count=0) unconditionally loads max=v, idx=0.
- Later beats replace max/idx only if v is strictly greater, so ties keep the lower index.
- State ACCUM:
  - Each accepted beat increments count.
  - If the accepted beat has count==NUM_CLASSES-1 and in_last=1: the update from that beat is included, then next cycle out_class/out_score are registered, out_valid=1, count=0, state=HOLD. Latency is 1 cycle from the final beat to out_valid.
  - If in_last=1 with count!=NUM_CLASSES-1 (early last): frame_err=1 for one cycle, frame dropped, count=0, stay in ACCUM, no output.
  - If count==NUM_CLASSES-1 and in_last=0 (missing last): frame_err=1 for one cycle, frame dropped, count=0, stay in ACCUM. The next beat starts a new frame.
- State HOLD:
  - in_ready=0.
  - out_valid, out_class and out_score remain stable until out_valid && out_ready.
  - On that handshake: out_valid=0 next cycle, state=ACCUM. in_ready returns to 1 in the cycle after the handshake, with no same-cycle bypass.
- out_ready is ignored when out_valid=0.
- out_class and out_score keep their last value after the handshake until the next result.
- Beat index counter width is CW; it never wraps because frames terminate at NUM_CLASSES-1.

Test Plan:
- Basic max, RELU_EN=1, NUM_CLASSES=4: beats 0x00008000, 0x00018000, 0x00004000, 0x00010000 with in_last on beat 3 -> one cycle later out_valid=1, out_class=1, out_score=0x00018000; hold with out_ready=0 for 5 cycles -> outputs stable, in_ready=0.
- Tie and sign handling, RELU_EN=0: beats 0x80008000, 0x80004000, 0x80004000, 0x80010000 -> out_class=1, out_score=0x80004000. Same frame with RELU_EN=1 -> out_class=0, out_score=0x00000000.
- Negative zero: beats 0x80000000, 0x00000000, 0x80000000, 0x80000001 with RELU_EN=0 -> out_class=0, out_score=0x00000000.
- Framing error: in_last asserted on beat 2 of 4 -> frame_err pulse of exactly 1 cycle, no out_valid. A following valid 4-beat frame is classified correctly.
- Backpressure: in_valid held high continuously across a frame boundary -> in_ready=0 during HOLD. Release out_ready after 3 cycles -> in_ready=1 the cycle after the handshake, and no beat is lost or duplicated.
- Reset mid-operation: rst asserted after 2 beats, and separately while in HOLD -> next cycle out_valid=0, in_ready=1, out_class=0, out_score=0. A subsequent full frame yields the correct result, unaffected by the pre-reset beats.

Source files
------------

// File: rtl/fc_argmax_classifier_if.sv
// Stream interface for the FC-layer argmax stage: neuron beats in, classification result out.
// The master drives beats and accepts results; the slave is the classifier.
interface fc_argmax_classifier_if #(
   parameter int unsigned N  = 32,
   parameter int unsigned CW = 4
);
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_data;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_class;
   logic [N-1:0]  out_score;
   logic          frame_err;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_class, out_score, frame_err
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_class, out_score, frame_err
   );
endinterface

// File: rtl/fc_argmax_classifier.sv
// Argmax over one frame of sign-magnitude FC neuron outputs, with optional ReLU.
// Reports the winning class index and score once per frame; flags malformed frames.
module fc_argmax_classifier #(
   parameter int unsigned NUM_CLASSES = 10,
   parameter int unsigned N           = 32,
   parameter int unsigned Q           = 15,
   parameter bit          RELU_EN     = 1'b1,
   parameter int unsigned CW          = $clog2(NUM_CLASSES)
) (
   input  logic                    clk,
   input  logic                    rst,
   fc_argmax_classifier_if.slave   bus
);

   if (NUM_CLASSES < 2 || Q >= N) begin : g_bad_params
      $error("fc_argmax_classifier: NUM_CLASSES must be >= 2 and Q < N");
   end

   typedef enum logic {
      ST_ACCUM,
      ST_HOLD
   } state_t;

   localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CLASSES - 1);

   state_t        r_state;
   logic [CW-1:0] r_count;
   logic [N-1:0]  r_max;
   logic [CW-1:0] r_idx;
   logic          r_out_valid;
   logic [CW-1:0] r_out_class;
   logic [N-1:0]  r_out_score;
   logic          r_frame_err;

   logic [N-1:0]  w_v;
   logic          w_gt;
   logic          w_first;
   logic          w_beat;
   logic          w_at_end;
   logic [N-1:0]  w_nmax;
   logic [CW-1:0] w_nidx;

   // Negatives (under ReLU) and both zero encodings collapse to all-zeros,
   // so the compare below never sees -0.
   always_comb begin
      w_v = bus.in_data;
      if ((RELU_EN && bus.in_data[N-1]) || (bus.in_data[N-2:0] == '0)) begin
         w_v = '0;
      end
   end

   always_comb begin
      w_gt = 1'b0;
      if (w_v[N-1] != r_max[N-1]) begin
         w_gt = r_max[N-1];
      end else if (!w_v[N-1]) begin
         w_gt = (w_v[N-2:0] > r_max[N-2:0]);
      end else begin
         w_gt = (w_v[N-2:0] < r_max[N-2:0]);
      end
   end

   always_comb begin
      w_first  = (r_count == '0);
      w_beat   = bus.in_valid && (r_state == ST_ACCUM);
      w_at_end = (r_count == LAST_IDX);
      w_nmax   = (w_first || w_gt) ? w_v : r_max;
      w_nidx   = w_first ? '0 : (w_gt ? r_count : r_idx);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_ACCUM;
         r_count     <= '0;
         r_max       <= '0;
         r_idx       <= '0;
         r_out_valid <= 1'b0;
         r_out_class <= '0;
         r_out_score <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         case (r_state)
            ST_ACCUM: begin
               if (w_beat) begin
                  r_max <= w_nmax;
                  r_idx <= w_nidx;
                  if (w_at_end && bus.in_last) begin
                     r_out_class <= w_nidx;
                     r_out_score <= w_nmax;
                     r_out_valid <= 1'b1;
                     r_count     <= '0;
                     r_state     <= ST_HOLD;
                  end else if (w_at_end || bus.in_last) begin
                     r_frame_err <= 1'b1;
                     r_count     <= '0;
                  end else begin
                     r_count <= r_count + CW'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_ACCUM;
               end
            end
         endcase
      end
   end

   assign bus.in_ready  = (r_state == ST_ACCUM);
   assign bus.out_valid = r_out_valid;
   assign bus.out_class = r_out_class;
   assign bus.out_score = r_out_score;
   assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_fc_argmax_classifier.sv
// Directed bench: two classifiers (ReLU on / off, 4 classes) driven with identical beats.
module tb_fc_argmax_classifier;

   localparam int unsigned NC = 4;
   localparam int unsigned N  = 32;
   localparam int unsigned CW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [N-1:0]  in_data = '0;
   logic          in_last = 1'b0;
   logic          out_ready = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fc_argmax_classifier_if #(.N(N), .CW(CW)) bus_r ();
   fc_argmax_classifier_if #(.N(N), .CW(CW)) bus_l ();

   assign bus_r.in_valid  = in_valid;
   assign bus_r.in_data   = in_data;
   assign bus_r.in_last   = in_last;
   assign bus_r.out_ready = out_ready;
   assign bus_l.in_valid  = in_valid;
   assign bus_l.in_data   = in_data;
   assign bus_l.in_last   = in_last;
   assign bus_l.out_ready = out_ready;

   fc_argmax_classifier #(.NUM_CLASSES(NC), .N(N), .Q(15), .RELU_EN(1'b1), .CW(CW)) u_dut_relu (
      .clk (clk),
      .rst (rst),
      .bus (bus_r.slave)
   );

   fc_argmax_classifier #(.NUM_CLASSES(NC), .N(N), .Q(15), .RELU_EN(1'b0), .CW(CW)) u_dut_lin (
      .clk (clk),
      .rst (rst),
      .bus (bus_l.slave)
   );

   task automatic beat(input logic [N-1:0] d, input logic l);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic frame(input logic [N-1:0] d0, d1, d2, d3);
      beat(d0, 1'b0);
      beat(d1, 1'b0);
      beat(d2, 1'b0);
      beat(d3, 1'b1);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({bus_r.in_ready, bus_r.out_valid, bus_r.out_class, bus_r.out_score, bus_r.frame_err}
          !== {1'b1, 1'b0, 2'd0, 32'h0, 1'b0}) begin
         bad++;
         $display("FAIL reset_relu: rdy=%b vld=%b cls=%0d score=%h err=%b required 1 0 0 00000000 0",
                  bus_r.in_ready, bus_r.out_valid, bus_r.out_class, bus_r.out_score, bus_r.frame_err);
      end
      total++;
      if ({bus_l.in_ready, bus_l.out_valid, bus_l.out_class, bus_l.out_score, bus_l.frame_err}
          !== {1'b1, 1'b0, 2'd0, 32'h0, 1'b0}) begin
         bad++;
         $display("FAIL reset_lin: rdy=%b vld=%b cls=%0d score=%h err=%b required 1 0 0 00000000 0",
                  bus_l.in_ready, bus_l.out_valid, bus_l.out_class, bus_l.out_score, bus_l.frame_err);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      frame(32'h0000_8000, 32'h0001_8000, 32'h0000_4000, 32'h0001_0000);
      total++;
      if ({bus_r.out_valid, bus_r.out_class, bus_r.out_score} !== {1'b1, 2'd1, 32'h0001_8000}) begin
         bad++;
         $display("FAIL basic_relu: vld=%b cls=%0d score=%h required 1 1 00018000",
                  bus_r.out_valid, bus_r.out_class, bus_r.out_score);
      end
      total++;
      if ({bus_l.out_valid, bus_l.out_class, bus_l.out_score} !== {1'b1, 2'd1, 32'h0001_8000}) begin
         bad++;
         $display("FAIL basic_lin: vld=%b cls=%0d score=%h required 1 1 00018000",
                  bus_l.out_valid, bus_l.out_class, bus_l.out_score);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         total++;
         if ({bus_r.out_valid, bus_r.out_class, bus_r.out_score, bus_r.in_ready}
             !== {1'b1, 2'd1, 32'h0001_8000, 1'b0}) begin
            bad++;
            $display("FAIL basic_hold[%0d]: vld=%b cls=%0d score=%h rdy=%b required 1 1 00018000 0",
                     i, bus_r.out_valid, bus_r.out_class, bus_r.out_score, bus_r.in_ready);
         end
      end
      drain();
      total++;
      if ({bus_r.out_valid, bus_r.in_ready, bus_r.out_class, bus_r.out_score}
          !== {1'b0, 1'b1, 2'd1, 32'h0001_8000}) begin
         bad++;
         $display("FAIL basic_release: vld=%b rdy=%b cls=%0d score=%h required 0 1 1 00018000",
                  bus_r.out_valid, bus_r.in_ready, bus_r.out_class, bus_r.out_score);
      end
   endtask

   task automatic test_tie_sign();
      frame(32'h8000_8000, 32'h8000_4000, 32'h8000_4000, 32'h8001_0000);
      total++;
      if ({bus_l.out_valid, bus_l.out_class, bus_l.out_score} !== {1'b1, 2'd1, 32'h8000_4000}) begin
         bad++;
         $display("FAIL tie_lin: vld=%b cls=%0d score=%h required 1 1 80004000",
                  bus_l.out_valid, bus_l.out_class, bus_l.out_score);
      end
      total++;
      if ({bus_r.out_valid, bus_r.out_class, bus_r.out_score} !== {1'b1, 2'd0, 32'h0}) begin
         bad++;
         $display("FAIL tie_relu: vld=%b cls=%0d score=%h required 1 0 00000000",
                  bus_r.out_valid, bus_r.out_class, bus_r.out_score);
      end
      drain();
   endtask

   task automatic test_neg_zero();
      frame(32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0001);
      total++;
      if ({bus_l.out_valid, bus_l.out_class, bus_l.out_score} !== {1'b1, 2'd0, 32'h0}) begin
         bad++;
         $display("FAIL negzero_lin: vld=%b cls=%0d score=%h required 1 0 00000000",
                  bus_l.out_valid, bus_l.out_class, bus_l.out_score);
      end
      total++;
      if ({bus_r.out_valid, bus_r.out_class, bus_r.out_score} !== {1'b1, 2'd0, 32'h0}) begin
         bad++;
         $display("FAIL negzero_relu: vld=%b cls=%0d score=%h required 1 0 00000000",
                  bus_r.out_valid, bus_r.out_class, bus_r.out_score);
      end
      drain();
   endtask

   task automatic test_frame_err();
      beat(32'h1, 1'b0);
      beat(32'h2, 1'b0);
      beat(32'h3, 1'b1);
      total++;
      if ({bus_r.frame_err, bus_r.out_valid, bus_l.frame_err, bus_l.out_valid} !== 4'b1010) begin
         bad++;
         $display("FAIL early_last_pulse: err_r=%b vld_r=%b err_l=%b vld_l=%b required 1 0 1 0",
                  bus_r.frame_err, bus_r.out_valid, bus_l.frame_err, bus_l.out_valid);
      end
      @(posedge clk); #1;
      total++;
      if ({bus_r.frame_err, bus_r.out_valid} !== 2'b00) begin
         bad++;
         $display("FAIL early_last_width: err=%b vld=%b required 0 0", bus_r.frame_err, bus_r.out_valid);
      end
      frame(32'h0000_0100, 32'h8000_0500, 32'h0000_0300, 32'h0000_0200);
      total++;
      if ({bus_l.out_valid, bus_l.out_class, bus_l.out_score} !== {1'b1, 2'd2, 32'h0000_0300}) begin
         bad++;
         $display("FAIL after_err_frame: vld=%b cls=%0d score=%h required 1 2 00000300",
                  bus_l.out_valid, bus_l.out_class, bus_l.out_score);
      end
      drain();
      for (int i = 0; i < 4; i++) begin
         beat(32'(i + 1), 1'b0);
      end
      total++;
      if ({bus_r.frame_err, bus_r.out_valid, bus_r.in_ready} !== 3'b101) begin
         bad++;
         $display("FAIL missing_last: err=%b vld=%b rdy=%b required 1 0 1",
                  bus_r.frame_err, bus_r.out_valid, bus_r.in_ready);
      end
      frame(32'h5, 32'h4, 32'h3, 32'h2);
      total++;
      if ({bus_r.out_valid, bus_r.out_class, bus_r.out_score} !== {1'b1, 2'd0, 32'h5}) begin
         bad++;
         $display("FAIL after_missing_last: vld=%b cls=%0d score=%h required 1 0 00000005",
                  bus_r.out_valid, bus_r.out_class, bus_r.out_score);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] a [4];
      logic [N-1:0] b [4];
      a = '{32'h100, 32'h200, 32'h300, 32'h400};
      b = '{32'h900, 32'h100, 32'h200, 32'h300};
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = a[i];
         in_last = (i == 3);
         @(posedge clk); #1;
      end
      in_data = b[0];
      in_last = 1'b0;
      total++;
      if ({bus_r.out_valid, bus_r.out_class, bus_r.out_score, bus_r.in_ready}
          !== {1'b1, 2'd3, 32'h400, 1'b0}) begin
         bad++;
         $display("FAIL b2b_first: vld=%b cls=%0d score=%h rdy=%b required 1 3 00000400 0",
                  bus_r.out_valid, bus_r.out_class, bus_r.out_score, bus_r.in_ready);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         total++;
         if ({bus_r.in_ready, bus_r.out_valid} !== 2'b01) begin
            bad++;
            $display("FAIL b2b_stall[%0d]: rdy=%b vld=%b required 0 1", i, bus_r.in_ready, bus_r.out_valid);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if ({bus_r.out_valid, bus_r.in_ready} !== 2'b01) begin
         bad++;
         $display("FAIL b2b_release: vld=%b rdy=%b required 0 1", bus_r.out_valid, bus_r.in_ready);
      end
      for (int i = 0; i < 4; i++) begin
         in_data = b[i];
         in_last = (i == 3);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      total++;
      if ({bus_l.out_valid, bus_l.out_class, bus_l.out_score, bus_l.frame_err}
          !== {1'b1, 2'd0, 32'h900, 1'b0}) begin
         bad++;
         $display("FAIL b2b_second: vld=%b cls=%0d score=%h err=%b required 1 0 00000900 0",
                  bus_l.out_valid, bus_l.out_class, bus_l.out_score, bus_l.frame_err);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      beat(32'h7FFF_FFFF, 1'b0);
      beat(32'h0000_0001, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++;
      if ({bus_l.out_valid, bus_l.in_ready, bus_l.out_class, bus_l.out_score}
          !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
         bad++;
         $display("FAIL rst_midframe: vld=%b rdy=%b cls=%0d score=%h required 0 1 0 00000000",
                  bus_l.out_valid, bus_l.in_ready, bus_l.out_class, bus_l.out_score);
      end
      frame(32'h10, 32'h20, 32'h30, 32'h5);
      total++;
      if ({bus_l.out_valid, bus_l.out_class, bus_l.out_score} !== {1'b1, 2'd2, 32'h30}) begin
         bad++;
         $display("FAIL rst_midframe_next: vld=%b cls=%0d score=%h required 1 2 00000030",
                  bus_l.out_valid, bus_l.out_class, bus_l.out_score);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++;
      if ({bus_r.out_valid, bus_r.in_ready, bus_r.out_class, bus_r.out_score}
          !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
         bad++;
         $display("FAIL rst_hold: vld=%b rdy=%b cls=%0d score=%h required 0 1 0 00000000",
                  bus_r.out_valid, bus_r.in_ready, bus_r.out_class, bus_r.out_score);
      end
      frame(32'h1, 32'h3, 32'h8000_0009, 32'h2);
      total++;
      if ({bus_l.out_valid, bus_l.out_class, bus_l.out_score} !== {1'b1, 2'd1, 32'h3}) begin
         bad++;
         $display("FAIL rst_hold_next: vld=%b cls=%0d score=%h required 1 1 00000003",
                  bus_l.out_valid, bus_l.out_class, bus_l.out_score);
      end
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_basic();
      test_tie_sign();
      test_neg_zero();
      test_frame_err();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
